// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared definitions for the single-beat AXI memory responder:
//   - bus widths (address, data, byte strobe)
//   - AXI response encodings
//   - read / write channel state enums
//   - addrInRange(): window decode helper used by both channels
// ---------------------------------------------------------------------------
package axi_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } readState_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_COMMIT,
        W_RESP
    } writeState_t;

    // True when addr falls inside [base, base + depth*8). Done in 64 bits so a
    // window ending exactly at the top of the 32-bit space cannot wrap.
    function automatic logic addrInRange(input logic [ADDR_W-1:0] addr,
                                         input logic [ADDR_W-1:0] base,
                                         input int                depth);
        logic [63:0] offset;
        logic [63:0] span;
        offset = 64'(addr) - 64'(base);
        span   = 64'(depth) << 3;
        return (addr >= base) && (offset < span);
    endfunction

endpackage

// File: rtl/sram_1r1w.sv
// ---------------------------------------------------------------------------
// sram_1r1w
// DEPTH x 64-bit memory with one synchronous read port and one byte-enabled
// write port. A read and a write to the same word in the same cycle return
// the old contents (read-first).
// Ports:
//   i_clk      clock
//   i_rdEn     load o_rdData from word i_rdIdx on this edge
//   i_rdIdx    read word index
//   o_rdData   registered read data, held until the next enabled read
//   i_wrEn     write enable
//   i_wrIdx    write word index
//   i_wrData   write data
//   i_wrStrb   per-byte write enables
// ---------------------------------------------------------------------------
module sram_1r1w
    import axi_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rdEn,
    input  logic [IDX_W-1:0]  i_rdIdx,
    output logic [DATA_W-1:0] o_rdData,
    input  logic              i_wrEn,
    input  logic [IDX_W-1:0]  i_wrIdx,
    input  logic [DATA_W-1:0] i_wrData,
    input  logic [STRB_W-1:0] i_wrStrb
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdData;

    // Both ports live in one clocked block; non-blocking semantics give the
    // read-first behaviour on a same-word collision.
    always_ff @(posedge i_clk) begin
        if (i_rdEn) begin
            r_rdData <= r_mem[i_rdIdx];
        end
        if (i_wrEn) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_wrStrb[b]) begin
                    r_mem[i_wrIdx][b*8 +: 8] <= i_wrData[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
// Single-beat AXI4-style memory responder backed by an internal 64-bit RAM.
// Reads answer after READ_LATENCY cycles, writes honour WSTRB, and addresses
// outside [BASE_ADDR, BASE_ADDR + DEPTH*8) return SLVERR without touching RAM.
// Ports:
//   ACLK, ARESET                       clock, synchronous active-high reset
//   AR*: ARVALID/ARREADY/ARADDR/ARPROT read address channel (ARPROT ignored)
//   R* : RVALID/RREADY/RDATA/RLAST/RRESP read data channel
//   AW*: AWVALID/AWREADY/AWADDR/AWPROT write address channel (AWPROT ignored)
//   W* : WVALID/WREADY/WDATA/WSTRB/WLAST write data channel (WLAST ignored)
//   B* : BVALID/BREADY/BRESP            write response channel
// ---------------------------------------------------------------------------
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h8000_0000,
    parameter int                DEPTH        = 4096,
    parameter int                READ_LATENCY = 1
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              ARVALID,
    output logic              ARREADY,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [2:0]        ARPROT,
    output logic              RVALID,
    input  logic              RREADY,
    output logic [DATA_W-1:0] RDATA,
    output logic              RLAST,
    output logic [1:0]        RRESP,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic [2:0]        AWPROT,
    input  logic              WVALID,
    output logic              WREADY,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [STRB_W-1:0] WSTRB,
    input  logic              WLAST,
    output logic              BVALID,
    input  logic              BREADY,
    output logic [1:0]        BRESP
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [15:0] WAIT_INIT = (READ_LATENCY > 1) ? 16'(READ_LATENCY - 2) : 16'd0;

    readState_t        r_readState;
    logic              r_arready;
    logic              r_rvalid;
    logic [1:0]        r_rresp;
    logic              r_rdErr;
    logic [IDX_W-1:0]  r_rdIdx;
    logic [15:0]       r_waitCnt;

    writeState_t       r_writeState;
    logic              r_awready;
    logic              r_wready;
    logic              r_awGot;
    logic              r_wGot;
    logic [ADDR_W-1:0] r_awAddr;
    logic [DATA_W-1:0] r_wData;
    logic [STRB_W-1:0] r_wStrb;
    logic              r_bvalid;
    logic [1:0]        r_bresp;

    logic              w_arFire;
    logic              w_awFire;
    logic              w_wFire;
    logic              w_arInRange;
    logic              w_wrInRange;
    logic [ADDR_W-1:0] w_arOffset;
    logic [ADDR_W-1:0] w_awOffset;
    logic [IDX_W-1:0]  w_arIdx;
    logic [IDX_W-1:0]  w_wrIdx;
    logic              w_ramRdEn;
    logic [IDX_W-1:0]  w_ramRdIdx;
    logic              w_ramWrEn;
    logic [DATA_W-1:0] w_ramRdData;
    logic              w_unused;

    assign w_arFire    = r_arready && ARVALID;
    assign w_awFire    = r_awready && AWVALID;
    assign w_wFire     = r_wready && WVALID;

    assign w_arInRange = addrInRange(ARADDR, BASE_ADDR, DEPTH);
    assign w_wrInRange = addrInRange(r_awAddr, BASE_ADDR, DEPTH);
    assign w_arOffset  = ARADDR - BASE_ADDR;
    assign w_awOffset  = r_awAddr - BASE_ADDR;
    assign w_arIdx     = w_arOffset[IDX_W+2:3];
    assign w_wrIdx     = w_awOffset[IDX_W+2:3];

    // The RAM is sampled on the edge that enters R_RESP: straight from ARADDR
    // when latency is 1, otherwise from the latched index at the end of R_WAIT.
    assign w_ramRdEn  = ((r_readState == R_IDLE) && w_arFire && (READ_LATENCY == 1)) ||
                        ((r_readState == R_WAIT) && (r_waitCnt == 16'd0));
    assign w_ramRdIdx = (r_readState == R_IDLE) ? w_arIdx : r_rdIdx;
    assign w_ramWrEn  = (r_writeState == W_COMMIT) && w_wrInRange;

    assign w_unused = ^{ARPROT, AWPROT, WLAST,
                        w_arOffset[2:0], w_arOffset[ADDR_W-1:IDX_W+3],
                        w_awOffset[2:0], w_awOffset[ADDR_W-1:IDX_W+3]};

    sram_1r1w #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_sram (
        .i_clk    (ACLK),
        .i_rdEn   (w_ramRdEn),
        .i_rdIdx  (w_ramRdIdx),
        .o_rdData (w_ramRdData),
        .i_wrEn   (w_ramWrEn),
        .i_wrIdx  (w_wrIdx),
        .i_wrData (r_wData),
        .i_wrStrb (r_wStrb)
    );

    // Read channel FSM. ARREADY is registered and re-armed on every edge that
    // leaves the FSM in R_IDLE, so it rises the cycle after reset release and
    // the cycle after each R handshake.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_readState <= R_IDLE;
            r_arready   <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rresp     <= RESP_OKAY;
            r_rdErr     <= 1'b0;
            r_rdIdx     <= '0;
            r_waitCnt   <= 16'd0;
        end else begin
            case (r_readState)
                R_IDLE: begin
                    if (w_arFire) begin
                        r_arready <= 1'b0;
                        r_rdIdx   <= w_arIdx;
                        r_rdErr   <= !w_arInRange;
                        if (READ_LATENCY == 1) begin
                            r_readState <= R_RESP;
                            r_rvalid    <= 1'b1;
                            r_rresp     <= w_arInRange ? RESP_OKAY : RESP_SLVERR;
                        end else begin
                            r_readState <= R_WAIT;
                            r_waitCnt   <= WAIT_INIT;
                        end
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (r_waitCnt == 16'd0) begin
                        r_readState <= R_RESP;
                        r_rvalid    <= 1'b1;
                        r_rresp     <= r_rdErr ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        r_waitCnt <= r_waitCnt - 16'd1;
                    end
                end
                R_RESP: begin
                    if (RREADY) begin
                        r_readState <= R_IDLE;
                        r_rvalid    <= 1'b0;
                        r_arready   <= 1'b1;
                    end
                end
                default: begin
                    r_readState <= R_IDLE;
                end
            endcase
        end
    end

    // Write channel FSM. AW and W are captured independently while idle; the
    // commit cycle starts once both are held, counting a capture on this edge.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_writeState <= W_IDLE;
            r_awready    <= 1'b0;
            r_wready     <= 1'b0;
            r_awGot      <= 1'b0;
            r_wGot       <= 1'b0;
            r_awAddr     <= '0;
            r_wData      <= '0;
            r_wStrb      <= '0;
            r_bvalid     <= 1'b0;
            r_bresp      <= RESP_OKAY;
        end else begin
            case (r_writeState)
                W_IDLE: begin
                    if (w_awFire) begin
                        r_awAddr  <= AWADDR;
                        r_awGot   <= 1'b1;
                        r_awready <= 1'b0;
                    end else if (!r_awGot) begin
                        r_awready <= 1'b1;
                    end
                    if (w_wFire) begin
                        r_wData  <= WDATA;
                        r_wStrb  <= WSTRB;
                        r_wGot   <= 1'b1;
                        r_wready <= 1'b0;
                    end else if (!r_wGot) begin
                        r_wready <= 1'b1;
                    end
                    if ((r_awGot || w_awFire) && (r_wGot || w_wFire)) begin
                        r_writeState <= W_COMMIT;
                        r_awGot      <= 1'b0;
                        r_wGot       <= 1'b0;
                    end
                end
                W_COMMIT: begin
                    r_writeState <= W_RESP;
                    r_bvalid     <= 1'b1;
                    r_bresp      <= w_wrInRange ? RESP_OKAY : RESP_SLVERR;
                end
                W_RESP: begin
                    if (BREADY) begin
                        r_writeState <= W_IDLE;
                        r_bvalid     <= 1'b0;
                        r_awready    <= 1'b1;
                        r_wready     <= 1'b1;
                    end
                end
                default: begin
                    r_writeState <= W_IDLE;
                end
            endcase
        end
    end

    assign ARREADY = r_arready;
    assign RVALID  = r_rvalid;
    assign RLAST   = r_rvalid;
    assign RRESP   = r_rresp;
    assign RDATA   = (r_rvalid && !r_rdErr) ? w_ramRdData : '0;
    assign AWREADY = r_awready;
    assign WREADY  = r_wready;
    assign BVALID  = r_bvalid;
    assign BRESP   = r_bresp;

endmodule

// File: tb/tb_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_slave
// Directed bench for axi_sram_slave. Two instances share clock, reset and the
// write channels: dut uses READ_LATENCY=1, dut3 uses READ_LATENCY=3 and has
// its own read channel.
// ---------------------------------------------------------------------------
module tb_axi_sram_slave;

    logic        ACLK = 1'b0;
    logic        ARESET;

    logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;
    logic [31:0] ARADDR;
    logic [2:0]  ARPROT;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;

    logic        ar3Valid, ar3Ready, r3Valid, r3Ready, r3Last;
    logic [31:0] ar3Addr;
    logic [63:0] r3Data;
    logic [1:0]  r3Resp;

    logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic [1:0]  BRESP;

    logic        aw3Ready, w3Ready, b3Valid;
    logic [1:0]  b3Resp;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    always #5 ACLK = ~ACLK;

    axi_sram_slave #(.BASE_ADDR(32'h8000_0000), .DEPTH(4096), .READ_LATENCY(1)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RLAST(RLAST), .RRESP(RRESP),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
    );

    axi_sram_slave #(.BASE_ADDR(32'h8000_0000), .DEPTH(4096), .READ_LATENCY(3)) dut3 (
        .ACLK(ACLK), .ARESET(ARESET),
        .ARVALID(ar3Valid), .ARREADY(ar3Ready), .ARADDR(ar3Addr), .ARPROT(ARPROT),
        .RVALID(r3Valid), .RREADY(r3Ready), .RDATA(r3Data), .RLAST(r3Last), .RRESP(r3Resp),
        .AWVALID(AWVALID), .AWREADY(aw3Ready), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(w3Ready), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .BVALID(b3Valid), .BREADY(BREADY), .BRESP(b3Resp)
    );

    // One comparison: counts it, and on mismatch reports tag/observed/expected.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic applyStimulus();
        @(posedge ACLK);
        #1;
    endtask

    // Full single-beat write with AW and W presented together.
    task automatic writeWord(input string tag, input logic [31:0] addr,
                             input logic [63:0] data, input logic [7:0] strb,
                             input logic [1:0] expResp);
        logic awPend, wPend, awHs, wHs;
        int   budget, waitCycles;
        awPend = 1'b1; wPend = 1'b1; budget = 0;
        AWVALID = 1'b1; AWADDR = addr;
        WVALID = 1'b1; WDATA = data; WSTRB = strb; WLAST = 1'b1;
        while ((awPend || wPend) && budget < 20) begin
            awHs = AWVALID && AWREADY;
            wHs  = WVALID && WREADY;
            applyStimulus();
            if (awHs) begin AWVALID = 1'b0; awPend = 1'b0; end
            if (wHs)  begin WVALID = 1'b0;  wPend = 1'b0;  end
            budget++;
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        checkOutput({tag, "_handshake"}, {62'd0, awPend, wPend}, 64'd0);
        waitCycles = 0;
        while (!BVALID && waitCycles < 20) begin
            applyStimulus();
            waitCycles++;
        end
        checkOutput({tag, "_blatency"}, 64'(waitCycles), 64'd1);
        checkOutput({tag, "_bresp"}, {62'd0, BRESP}, {62'd0, expResp});
        BREADY = 1'b1;
        applyStimulus();
        BREADY = 1'b0;
        checkOutput({tag, "_bdone"}, {63'd0, BVALID}, 64'd0);
    endtask

    // Full single-beat read on the latency-1 instance.
    task automatic readWord(input string tag, input logic [31:0] addr,
                            input logic [63:0] expData, input logic [1:0] expResp);
        logic arPend, arHs;
        int   budget, waitCycles;
        arPend = 1'b1; budget = 0;
        ARVALID = 1'b1; ARADDR = addr;
        while (arPend && budget < 20) begin
            arHs = ARVALID && ARREADY;
            applyStimulus();
            if (arHs) begin ARVALID = 1'b0; arPend = 1'b0; end
            budget++;
        end
        ARVALID = 1'b0;
        checkOutput({tag, "_arhandshake"}, {63'd0, arPend}, 64'd0);
        waitCycles = 0;
        while (!RVALID && waitCycles < 20) begin
            applyStimulus();
            waitCycles++;
        end
        checkOutput({tag, "_rlatency"}, 64'(waitCycles), 64'd0);
        checkOutput({tag, "_rdata"}, RDATA, expData);
        checkOutput({tag, "_rresp"}, {62'd0, RRESP}, {62'd0, expResp});
        checkOutput({tag, "_rlast"}, {63'd0, RLAST}, 64'd1);
        RREADY = 1'b1;
        applyStimulus();
        RREADY = 1'b0;
        checkOutput({tag, "_rdone"}, {62'd0, RVALID, ARREADY}, 64'd1);
    endtask

    initial begin
        ARESET = 1'b1;
        ARVALID = 1'b0; ARADDR = '0; ARPROT = '0; RREADY = 1'b0;
        ar3Valid = 1'b0; ar3Addr = '0; r3Ready = 1'b0;
        AWVALID = 1'b0; AWADDR = '0; AWPROT = '0;
        WVALID = 1'b0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; BREADY = 1'b0;

        // Reset values
        repeat (3) applyStimulus();
        checkOutput("rst_ready", {61'd0, ARREADY, AWREADY, WREADY}, 64'd0);
        checkOutput("rst_valid", {61'd0, RVALID, RLAST, BVALID}, 64'd0);
        checkOutput("rst_rdata", RDATA, 64'd0);
        checkOutput("rst_resp", {60'd0, RRESP, BRESP}, 64'd0);
        ARESET = 1'b0;
        applyStimulus();
        checkOutput("post_rst_ready", {61'd0, ARREADY, AWREADY, WREADY}, 64'h7);
        checkOutput("post_rst_ready3", {63'd0, ar3Ready}, 64'd1);

        // Full write, readback, then partial-strobe overwrite
        writeWord("wr_full", 32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 2'b00);
        readWord("rd_full", 32'h8000_0010, 64'h1122_3344_5566_7788, 2'b00);
        writeWord("wr_part", 32'h8000_0010, 64'hFFFF_FFFF_AAAA_BBBB, 8'h0F, 2'b00);
        readWord("rd_part", 32'h8000_0010, 64'h1122_3344_AAAA_BBBB, 2'b00);

        // Window edges: last word in range, first words outside on both sides.
        // 0x8000_8000 would alias word 0 if the decode dropped the upper bits.
        writeWord("wr_word0", 32'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'b00);
        writeWord("wr_last", 32'h8000_7FF8, 64'hCAFE_F00D_0BAD_BEEF, 8'hFF, 2'b00);
        readWord("rd_last", 32'h8000_7FF8, 64'hCAFE_F00D_0BAD_BEEF, 2'b00);
        readWord("rd_below", 32'h7FFF_FFF8, 64'd0, 2'b10);
        readWord("rd_above", 32'h8000_8000, 64'd0, 2'b10);
        writeWord("wr_above", 32'h8000_8000, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF, 2'b10);
        readWord("rd_word0_kept", 32'h8000_0000, 64'h0123_4567_89AB_CDEF, 2'b00);

        // W three cycles before AW, WLAST low, BREADY held off five cycles
        WVALID = 1'b1; WDATA = 64'h5A5A_0000_1234_5678; WSTRB = 8'hFF; WLAST = 1'b0;
        applyStimulus();
        WVALID = 1'b0;
        checkOutput("wfirst_ready", {62'd0, AWREADY, WREADY}, 64'h2);
        applyStimulus();
        applyStimulus();
        checkOutput("wfirst_nob", {63'd0, BVALID}, 64'd0);
        AWVALID = 1'b1; AWADDR = 32'h8000_0020;
        applyStimulus();
        AWVALID = 1'b0;
        checkOutput("wfirst_commit", {62'd0, AWREADY, BVALID}, 64'd0);
        applyStimulus();
        for (int i = 0; i < 5; i++) begin
            checkOutput("wfirst_bhold", {61'd0, BVALID, BRESP}, 64'h4);
            applyStimulus();
        end
        BREADY = 1'b1;
        applyStimulus();
        BREADY = 1'b0;
        checkOutput("wfirst_bdone", {63'd0, BVALID}, 64'd0);
        applyStimulus();
        checkOutput("wfirst_single", {61'd0, BVALID, AWREADY, WREADY}, 64'h3);

        // Read of that word with RREADY held off five cycles
        ARVALID = 1'b1; ARADDR = 32'h8000_0020;
        applyStimulus();
        ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("rhold_valid", {60'd0, RVALID, RLAST, RRESP}, 64'hC);
            checkOutput("rhold_data", RDATA, 64'h5A5A_0000_1234_5678);
            applyStimulus();
        end
        RREADY = 1'b1;
        applyStimulus();
        RREADY = 1'b0;
        checkOutput("rhold_done", {62'd0, RVALID, ARREADY}, 64'h1);

        // READ_LATENCY=3 instance: RVALID three cycles after AR handshake
        ar3Valid = 1'b1; ar3Addr = 32'h8000_0010;
        applyStimulus();
        ar3Valid = 1'b0;
        checkOutput("lat3_n1", {62'd0, r3Valid, ar3Ready}, 64'd0);
        applyStimulus();
        checkOutput("lat3_n2", {63'd0, r3Valid}, 64'd0);
        applyStimulus();
        checkOutput("lat3_n3", {61'd0, r3Valid, r3Resp}, 64'h4);
        checkOutput("lat3_data", r3Data, 64'h1122_3344_AAAA_BBBB);
        ar3Valid = 1'b1; ar3Addr = 32'h8000_0000; r3Ready = 1'b1;
        applyStimulus();
        r3Ready = 1'b0;
        checkOutput("lat3_b2b_ready", {62'd0, r3Valid, ar3Ready}, 64'h1);
        applyStimulus();
        ar3Valid = 1'b0;
        checkOutput("lat3_b2b_taken", {63'd0, ar3Ready}, 64'd0);
        applyStimulus();
        applyStimulus();
        checkOutput("lat3_b2b_data", {r3Valid, r3Last, r3Data[61:0]},
                    {2'b11, 62'h0123_4567_89AB_CDEF});
        r3Ready = 1'b1;
        applyStimulus();
        r3Ready = 1'b0;
        checkOutput("lat3_b2b_done", {62'd0, r3Valid, ar3Ready}, 64'h1);

        // Reset with dut3 in R_WAIT and AW captured but W not yet
        writeWord("wr_target", 32'h8000_0030, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 2'b00);
        ar3Valid = 1'b1; ar3Addr = 32'h8000_0030;
        applyStimulus();
        ar3Valid = 1'b0;
        AWVALID = 1'b1; AWADDR = 32'h8000_0030;
        applyStimulus();
        AWVALID = 1'b0;
        checkOutput("abort_awonly", {62'd0, AWREADY, WREADY}, 64'h1);
        WVALID = 1'b1; WDATA = 64'h0; WSTRB = 8'hFF; ARESET = 1'b1;
        applyStimulus();
        WVALID = 1'b0;
        applyStimulus();
        checkOutput("abort_rst_ready", {59'd0, ARREADY, AWREADY, WREADY, ar3Ready, aw3Ready}, 64'd0);
        checkOutput("abort_rst_valid", {60'd0, RVALID, r3Valid, r3Last, BVALID}, 64'd0);
        checkOutput("abort_rst_r3data", r3Data, 64'd0);
        checkOutput("abort_rst_resp", {60'd0, r3Resp, BRESP}, 64'd0);
        ARESET = 1'b0;
        repeat (4) applyStimulus();
        checkOutput("abort_no_resp", {61'd0, r3Valid, BVALID, b3Valid}, 64'd0);
        checkOutput("abort_ready", {61'd0, ar3Ready, AWREADY, WREADY}, 64'h7);
        readWord("rd_target_kept", 32'h8000_0030, 64'hA5A5_A5A5_A5A5_A5A5, 2'b00);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

Single-beat AXI4-style memory responder: the slave end of the read (AR/R) and write (AW/W/B) channels driven by the core's `mem_read`/`mem_write` initiators. Holds an internal 64-bit-wide RAM, answers reads after a programmable latency, commits byte-strobed writes, and returns SLVERR for out-of-window addresses. It replaces the DPI `pmem` model in synthesizable/FPGA builds.

## Interface
- `BASE_ADDR`, 32'h8000_0000, first byte address of the memory window
- `DEPTH`, 4096, number of 64-bit words (power of two)
- `READ_LATENCY`, 1, cycles from AR handshake to RVALID (≥1)
- `ACLK  in  1  clock`
- `ARESET  in  1  synchronous reset, active-high`
- `ARVALID in 1`, `ARREADY out 1`, `ARADDR in 32`, `ARPROT in 3 (ignored)`
- `RVALID out 1`, `RREADY in 1`, `RDATA out 64`, `RLAST out 1`, `RRESP out 2`
- `AWVALID in 1`, `AWREADY out 1`, `AWADDR in 32`, `AWPROT in 3 (ignored)`
- `WVALID in 1`, `WREADY out 1`, `WDATA in 64`, `WSTRB in 8 (byte enables)`, `WLAST in 1`
- `BVALID out 1`, `BREADY in 1`, `BRESP out 2`

## Operation
- Address decode: in-range iff `ADDR >= BASE_ADDR` and `ADDR - BASE_ADDR < DEPTH*8`; word index = `(ADDR - BASE_ADDR) >> 3`; `ADDR[2:0]` ignored. Response OKAY=2'b00, SLVERR=2'b10.
- Read FSM: R_IDLE → (ARVALID) latch addr → R_WAIT (count READ_LATENCY−1 cycles; skipped if latency 1) → R_RESP. R_RESP holds RVALID=1, RLAST=1, RDATA, RRESP stable until RREADY=1, then R_IDLE.
- Read data sampled from RAM on the cycle of entry to R_RESP; out-of-range → RDATA=0, RRESP=SLVERR.
- Write FSM: W_IDLE accepts AW and W independently (either order or same cycle); each channel's READY drops once that channel is captured. When both captured → W_COMMIT (one cycle: write bytes where WSTRB[i]=1; out-of-range → no write) → W_RESP: BVALID=1 until BREADY, then W_IDLE.
- WLAST=0 is tolerated and treated as last (single-beat only); BRESP unaffected.
- Read and write FSMs independent; both may be mid-transaction concurrently.
- Same-word write commit and read sample in the same cycle: read returns pre-write data.

## Timing
- Reset values: ARREADY=0, AWREADY=0, WREADY=0, RVALID=0, RLAST=0, RDATA=0, RRESP=0, BVALID=0, BRESP=0; FSMs to IDLE. RAM contents not cleared.
- ARREADY=1 exactly in R_IDLE (first cycle after reset release); AWREADY/WREADY=1 in W_IDLE until respective capture.
- Read latency: AR handshake at cycle N → RVALID at N+READY_LATENCY; back-to-back reads: next ARREADY the cycle after R handshake.
- Write: AW+W handshake same cycle N → commit N+1 → BVALID N+2. AW at N, W at N+k → BVALID at N+k+2.
- RVALID/BVALID never deasserted without handshake; outputs registered (no combinational VALID←READY path).
- ARESET mid-transaction: in-flight transaction aborted, no response issued, pending write not committed unless W_COMMIT already executed.

## Structure
- Package `axi_pkg`: RESP_OKAY/RESP_SLVERR constants, read/write state enums, address/data width constants.
- Sub-module `sram_1r1w` (DEPTH×64, byte-write-enable, synchronous read, read-first) holding the array; FSMs and decode in top.

## Test plan
- Write 64'h1122_3344_5566_7788, WSTRB=8'hFF at 0x8000_0010, then read 0x8000_0010 → RDATA matches, RRESP=00, RLAST=1, BRESP=00.
- Partial write WSTRB=8'h0F, WDATA=64'hFFFF_FFFF_AAAA_BBBB over prior word → readback 64'h1122_3344_AAAA_BBBB.
- Read 0x7FFF_FFF8 and write 0x8000_8000 (DEPTH=4096) → RRESP=BRESP=10, RDATA=0, RAM unchanged.
- W before AW by 3 cycles; RREADY/BREADY held low 5 cycles → VALID and data stable throughout, single response each.
- READ_LATENCY=3: AR handshake cycle 10 → RVALID cycle 13; back-to-back reads give ARREADY cycle after each R handshake.
- ARESET asserted in R_WAIT and with AW captured but not W → all outputs reset values, no B/R response, target word unchanged.
